// File: rtl/bp_be_issue_queue_pkg.sv
// Shared sizing constants for the back-end issue queue.
// width_p of the queue defaults to the FE/BE interface packet width below.
package bp_be_issue_queue_pkg;

    // Width of one fe_queue packet as seen by the back end.
    localparam int fe_queue_width_lp  = 32;
    localparam int issue_queue_els_lp = 8;

    // A pointer carries one extra wrap bit above the entry index.
    function automatic int ptr_width(input int els);
        return $clog2(els) + 1;
    endfunction

endpackage

// File: rtl/bp_be_issue_queue_ptr.sv
// Circular pointer with a wrap bit; a load takes priority over an increment.
module bp_be_issue_queue_ptr #(
    parameter int width_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               inc_i,
    input  logic               load_i,
    input  logic [width_p-1:0] load_val_i,
    output logic [width_p-1:0] ptr_o
);

    logic [width_p-1:0] r_ptr;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_ptr <= '0;
        end else if (load_i) begin
            r_ptr <= load_val_i;
        end else if (inc_i) begin
            r_ptr <= r_ptr + width_p'(1);
        end
    end

    assign ptr_o = r_ptr;

endmodule

// File: rtl/bp_be_issue_queue.sv
// Checkpointing FIFO between the front-end fetch queue and the back-end checker.
// Optional same-cycle bypass from fe_queue_i is enabled by BP_BE_ISSUE_QUEUE_BYPASS_EN.
module bp_be_issue_queue
    import bp_be_issue_queue_pkg::*;
#(
    parameter int els_p   = issue_queue_els_lp,
    parameter int width_p = fe_queue_width_lp
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] fe_queue_i,
    input  logic               fe_queue_v_i,
    output logic               fe_queue_ready_o,
    output logic [width_p-1:0] fe_queue_o,
    output logic               fe_queue_v_o,
    input  logic               fe_queue_yumi_i,
    input  logic               fe_queue_clr_i,
    input  logic               fe_queue_deq_i,
    input  logic               fe_queue_roll_i,
    output logic               empty_o
);

    localparam int lg_els_lp = $clog2(els_p);
    localparam int ptr_w_lp  = ptr_width(els_p);

    logic [ptr_w_lp-1:0] w_wptr;
    logic [ptr_w_lp-1:0] w_rptr;
    logic [ptr_w_lp-1:0] w_cptr;
    logic [ptr_w_lp-1:0] w_cptr_after_deq;
    logic [ptr_w_lp-1:0] w_rptr_load_val;
    logic                w_full;
    logic                w_enq;
    logic                w_unread;
    logic                w_rptr_load;

    logic [width_p-1:0] r_mem [els_p];

    // Handshakes: an entry is accepted on any edge where fe_queue_v_i & fe_queue_ready_o;
    // the checker consumes fe_queue_o on an edge where fe_queue_yumi_i is high, which it
    // may only do while fe_queue_v_o is high (yumi is a same-cycle acknowledge, not a request).
    assign w_full           = ((w_wptr - w_cptr) == ptr_w_lp'(els_p));
    assign fe_queue_ready_o = ~w_full;
    assign w_enq            = fe_queue_v_i & ~w_full;
    assign w_unread         = (w_rptr != w_wptr);
    assign empty_o          = (w_cptr == w_wptr);

    // A roll lands on the checkpoint as it stands after any same-cycle deq.
    assign w_cptr_after_deq = fe_queue_deq_i ? (w_cptr + ptr_w_lp'(1)) : w_cptr;
    assign w_rptr_load      = fe_queue_clr_i | fe_queue_roll_i;
    assign w_rptr_load_val  = fe_queue_clr_i ? w_wptr : w_cptr_after_deq;

    bp_be_issue_queue_ptr #(.width_p(ptr_w_lp)) u_wptr (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .inc_i      (w_enq),
        .load_i     (1'b0),
        .load_val_i ('0),
        .ptr_o      (w_wptr)
    );

    bp_be_issue_queue_ptr #(.width_p(ptr_w_lp)) u_rptr (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .inc_i      (fe_queue_yumi_i),
        .load_i     (w_rptr_load),
        .load_val_i (w_rptr_load_val),
        .ptr_o      (w_rptr)
    );

    bp_be_issue_queue_ptr #(.width_p(ptr_w_lp)) u_cptr (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .inc_i      (fe_queue_deq_i & ~fe_queue_clr_i),
        .load_i     (fe_queue_clr_i),
        .load_val_i (w_wptr),
        .ptr_o      (w_cptr)
    );

    // Storage is never cleared; the pointers alone decide which entries are live.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[w_wptr[lg_els_lp-1:0]] <= fe_queue_i;
        end
    end

`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
    logic w_bypass;

    // The bypassed entry is still written so a later roll can replay it.
    assign w_bypass     = w_enq & ~w_unread & ~fe_queue_clr_i & ~fe_queue_roll_i;
    assign fe_queue_v_o = w_unread | w_bypass;
    assign fe_queue_o   = w_bypass ? fe_queue_i : r_mem[w_rptr[lg_els_lp-1:0]];
`else
    assign fe_queue_v_o = w_unread;
    assign fe_queue_o   = r_mem[w_rptr[lg_els_lp-1:0]];
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            a_yumi_needs_valid: assert (!(fe_queue_yumi_i && !fe_queue_v_o));
            a_deq_needs_consumed: assert (!(fe_queue_deq_i && !fe_queue_clr_i
                                            && (w_cptr == w_rptr)
                                            && !(fe_queue_yumi_i && !fe_queue_roll_i)));
        end
    end

endmodule

// File: doc/bp_be_issue_queue.md
Name: bp_be_issue_queue

Overview:
Checkpointing FIFO between the front-end fetch output and the back-end checker. It buffers fe_queue packets and presents them to the checker through the yumi/clr/deq/roll interface. Entries are consumed speculatively, committed on retire, and can be replayed after a pipeline flush. It gives the back end precise replay of fetched instructions without refetching from the front end.

Parameters:
els_p, 8, queue depth; must be a power of 2 and at least 2.
width_p, fe_queue_width_lp, packet width in bits.

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
fe_queue_i  in  width_p  packet from the front end
fe_queue_v_i  in  1  enqueue valid
fe_queue_ready_o  out  1  space available (ready/valid handshake)
fe_queue_o  out  width_p  packet at the speculative read pointer
fe_queue_v_o  out  1  unread packet available
fe_queue_yumi_i  in  1  checker consumes fe_queue_o
fe_queue_clr_i  in  1  discard all stored entries
fe_queue_deq_i  in  1  commit the oldest consumed entry
fe_queue_roll_i  in  1  rewind the read pointer to the checkpoint
empty_o  out  1  no committed-pending or unread entries (cptr == wptr)

Behaviour:
- Pointers:
  - Three pointers, each log2(els_p)+1 bits including a wrap bit: wptr (write), rptr (speculative read), cptr (checkpoint, oldest uncommitted).
  - Invariant: cptr <= rptr <= wptr, in modular order.
- Reset: all pointers 0. fe_queue_ready_o=1, fe_queue_v_o=0, empty_o=1.
- Status:
  - full = (wptr - cptr == els_p). fe_queue_ready_o = ~full; it depends on registered state only.
  - fe_queue_v_o = (rptr != wptr). fe_queue_o = mem[rptr], read combinationally.
  - fe_queue_o is don't-care when fe_queue_v_o=0.
- Enqueue: when fe_queue_v_i & fe_queue_ready_o, write mem[wptr] and increment wptr.
  - Write-to-read latency is 1 cycle: the entry is visible the cycle after the handshake.
- Yumi: increments rptr.
  - Asserting it with fe_queue_v_o=0 is illegal (assertion).
- Deq: increments cptr.
  - Asserting it with cptr==rptr, before the yumi for that entry, is illegal (assertion).
- Same-cycle priority: clr > roll > yumi.
  - clr: rptr and cptr take the pre-update wptr. A same-cycle enqueue is kept, so the queue then holds exactly that one entry. Deq, roll and yumi are ignored.
  - roll (no clr): a same-cycle deq is applied first; then rptr takes the new cptr. Yumi is ignored. A same-cycle enqueue is kept.
  - yumi and deq in the same cycle: both pointers increment.
- Wrap-around: the index is the low log2(els_p) bits. The wrap bit distinguishes full from empty.
- Full boundary: with els_p entries outstanding (some consumed but not deq'd), ready stays low. Only deq or clr frees space; yumi alone does not.
- Reset mid-operation: all entries are lost and the pointers return to 0 on the next edge. The memory contents are not cleared.

Optional Feature:
BP_BE_ISSUE_QUEUE_BYPASS_EN
- Defined: when rptr==wptr and fe_queue_v_i & fe_queue_ready_o, fe_queue_o = fe_queue_i and fe_queue_v_o=1 in the same cycle (0-cycle latency).
  - If yumi is also asserted, rptr increments along with wptr.
  - The entry is still written to mem so that roll can replay it.
  - Bypass is suppressed in a clr or roll cycle.
- Undefined: 1-cycle write-to-read latency as above. There is no combinational path from the fe_queue_i / fe_queue_v_i inputs to fe_queue_o / fe_queue_v_o.

Decomposition:
- No new typedefs. width_p comes from the existing fe_queue width macro in the FE/BE interface package.
- One sub-module, bp_be_issue_queue_ptr: a wrap-bit circular pointer with inc_i, load_i and load_val_i.
  - Instantiated three times.
  - load has priority over inc.
- Storage is a flop array of els_p x width_p, written on enqueue.

Test Plan:
1. After reset, enqueue A,B,C on consecutive cycles, then yumi 3 times -> outputs A,B,C in order; fe_queue_v_o=0 afterward; empty_o=0 until 3 deqs, then 1.
2. Enqueue A..D; yumi A,B; deq A; roll -> fe_queue_o=B, v_o=1; yumi B,C,D -> B,C,D.
3. els_p=8: enqueue 8 entries -> ready_o=0 on the 9th; yumi all 8 -> ready_o stays 0; one deq -> ready_o=1 the next cycle.
4. With 3 entries outstanding: assert clr together with an enqueue of X -> the next cycle fe_queue_o=X, v_o=1, and exactly one entry is present.
5. Wrap: 20 enqueue/yumi/deq round-trips with deq lagging by 2 -> data order preserved across 2.5 wraps, with no spurious full or empty.
6. With BYPASS_EN, from empty: enqueue Y with yumi in the same cycle -> fe_queue_o=Y in that cycle; a subsequent roll replays Y.
